// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: request/address out, acknowledge/data back.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC/IR, memory read handshake, IR field decode; FETCH_TIMEOUT_EN adds stalled-read retry.
// Latency: IRWrite to valid IR is 2+ cycles; PC updates are visible one cycle after the strobe.
// Backpressure: mem_req is held until mem_ack; IRWrite is ignored while a fetch is outstanding.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               IRWrite,
    input  logic               PCWrite,
    input  logic [1:0]         Jcontrol,
    input  logic [15:0]        jr_target,
    instr_fetch_unit_if.master mem,
    output logic [3:0]         Opcode,
    output logic [2:0]         Func,
    output logic               toaccIn,
    output logic               noOp,
    output logic [15:0]        ir,
    output logic [15:0]        imm_sext,
    output logic [15:0]        pc,
    output logic               fetch_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RETRY = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] fetch_addr;
    logic        inc_done;
    logic        start_fetch;
    logic        take_ack;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
    logic        timeout;

    assign timeout = (state == REQ) && !mem.mem_ack && (to_cnt == TO_LAST);
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        take_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (IRWrite) begin
                    start_fetch = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    take_ack  = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = RETRY;
                end
`endif
            end
            // One cycle with the request withdrawn, then re-issue at the same address.
            RETRY:   state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc         <= RESET_PC;
            ir         <= 16'h0000;
            noOp       <= 1'b1;
            fetch_addr <= RESET_PC;
            inc_done   <= 1'b0;
        end else begin
            if (PCWrite) begin
                case (Jcontrol)
                    2'd0: begin
                        // Sequential advance is allowed once per fetched instruction.
                        if (!noOp && !inc_done) begin
                            pc       <= pc + 16'd1;
                            inc_done <= 1'b1;
                        end
                    end
                    2'd1:    pc <= pc + imm_sext;
                    2'd2:    pc <= {pc[15:12], ir[11:0]};
                    default: pc <= jr_target;
                endcase
            end
            if (start_fetch) begin
                fetch_addr <= pc;
                noOp       <= 1'b1;
            end
            if (take_ack) begin
                ir       <= mem.mem_rdata;
                noOp     <= 1'b0;
                inc_done <= 1'b0;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            to_cnt    <= 16'd0;
            fetch_err <= 1'b0;
        end else begin
            if (take_ack || timeout) begin
                to_cnt <= 16'd0;
            end else if (state == REQ) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (timeout) begin
                fetch_err <= 1'b1;
            end
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    assign mem.mem_req  = (state == REQ);
    assign mem.mem_addr = fetch_addr;

    assign Opcode   = ir[15:12];
    assign Func     = ir[2:0];
    assign toaccIn  = ir[3];
    assign imm_sext = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed test-plan cases followed by randomized traffic.
module tb_instr_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0010;
    localparam int          TO     = 4;

    logic        CLK = 1'b0;
    logic        Reset, IRWrite, PCWrite;
    logic [1:0]  Jcontrol;
    logic [15:0] jr_target;
    logic [3:0]  Opcode;
    logic [2:0]  Func;
    logic        toaccIn, noOp, fetch_err;
    logic [15:0] ir, imm_sext, pc;

    instr_fetch_unit_if mem_if ();

    instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Jcontrol(Jcontrol), .jr_target(jr_target), .mem(mem_if),
        .Opcode(Opcode), .Func(Func), .toaccIn(toaccIn), .noOp(noOp),
        .ir(ir), .imm_sext(imm_sext), .pc(pc), .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] pc, ir, addr;
        bit          noop, req, err;
    } snap_t;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  fn;
        bit          ta;
        logic [15:0] imm;
    } dec_t;

    snap_t       cyc_q[$];
    logic [15:0] addr_q[$];
    dec_t        dec_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: architectural state only.
    logic [15:0] m_pc, m_ir, m_addr;
    bit          m_valid, m_inc, m_busy, m_gap, m_err;
    int          m_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] sext8(input int b);
        int v;
        v = b % 256;
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    task automatic step(input bit rst, input bit irw, input bit pcw, input logic [1:0] jc,
                        input logic [15:0] jr, input bit ack, input logic [15:0] rd);
        logic [15:0] nxt_pc;
        bit          bump;
        snap_t       s;
        dec_t        d;
        @(negedge CLK);
        Reset = rst; IRWrite = irw; PCWrite = pcw; Jcontrol = jc; jr_target = jr;
        mem_if.mem_ack = ack; mem_if.mem_rdata = rd;
        if (rst) begin
            m_pc = RST_PC; m_ir = 16'h0000; m_addr = RST_PC;
            m_valid = 0; m_inc = 0; m_busy = 0; m_gap = 0; m_err = 0; m_wait = 0;
        end else begin
            nxt_pc = m_pc;
            bump   = 0;
            if (pcw) begin
                case (jc)
                    2'd0: if (m_valid && !m_inc) begin nxt_pc = m_pc + 16'd1; bump = 1; end
                    2'd1: nxt_pc = m_pc + sext8(int'(m_ir));
                    2'd2: nxt_pc = (m_pc & 16'hF000) | (m_ir & 16'h0FFF);
                    default: nxt_pc = jr;
                endcase
            end
            if (!m_busy) begin
                if (irw) begin
                    m_addr = m_pc; m_valid = 0; m_busy = 1; m_wait = 0;
                    addr_q.push_back(m_pc);
                end
            end else if (m_gap) begin
                m_gap = 0;
                addr_q.push_back(m_addr);
            end else if (ack) begin
                m_ir = rd; m_valid = 1; m_inc = 0; m_busy = 0; m_wait = 0;
                d.op  = 4'(int'(rd) / 4096);
                d.fn  = 3'(int'(rd) % 8);
                d.ta  = ((int'(rd) / 8) % 2) == 1;
                d.imm = sext8(int'(rd));
                dec_q.push_back(d);
            end else begin
`ifdef FETCH_TIMEOUT_EN
                m_wait++;
                if (m_wait == TO) begin m_wait = 0; m_gap = 1; m_err = 1; end
`endif
            end
            m_pc = nxt_pc;
            if (bump) m_inc = 1;
        end
        s.pc = m_pc; s.ir = m_ir; s.addr = m_addr;
        s.noop = !m_valid; s.req = m_busy && !m_gap; s.err = m_err;
        cyc_q.push_back(s);
        @(posedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 16'h0, 0, 16'h0);
    endtask

    task automatic fetch(input logic [15:0] rd, input int wait_cyc);
        step(0, 1, 0, 2'd0, 16'h0, 0, 16'h0);
        idle(wait_cyc);
        step(0, 0, 0, 2'd0, 16'h0, 1, rd);
    endtask

    task automatic pc_op(input logic [1:0] jc, input logic [15:0] jr);
        step(0, 0, 1, jc, jr, 0, 16'h0);
    endtask

    // Monitor: compares every cycle and pops fetch/decode events as the DUT presents them.
    bit    prev_req  = 0;
    bit    prev_noop = 1;
    snap_t ms;
    dec_t  md;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (cyc_q.size() != 0) begin
                ms = cyc_q.pop_front();
                check("pc", 32'(pc), 32'(ms.pc));
                check("ir", 32'(ir), 32'(ms.ir));
                check("noOp", 32'(noOp), 32'(ms.noop));
                check("mem_req", 32'(mem_if.mem_req), 32'(ms.req));
                check("fetch_err", 32'(fetch_err), 32'(ms.err));
                if (ms.req) check("mem_addr_stable", 32'(mem_if.mem_addr), 32'(ms.addr));
                if (mem_if.mem_req === 1'b1 && !prev_req) begin
                    if (addr_q.size() != 0) check("fetch_addr", 32'(mem_if.mem_addr), 32'(addr_q.pop_front()));
                    else check("req_rise_queue", 32'(addr_q.size()), 32'd1);
                end
                if (noOp === 1'b0 && prev_noop) begin
                    if (dec_q.size() != 0) begin
                        md = dec_q.pop_front();
                        check("Opcode", 32'(Opcode), 32'(md.op));
                        check("Func", 32'(Func), 32'(md.fn));
                        check("toaccIn", 32'(toaccIn), 32'(md.ta));
                        check("imm_sext", 32'(imm_sext), 32'(md.imm));
                    end else check("valid_rise_queue", 32'(dec_q.size()), 32'd1);
                end
                prev_req  = (mem_if.mem_req === 1'b1);
                prev_noop = (noOp !== 1'b0);
            end
        end
    end

    initial begin
        bit ack;
        Reset = 1; IRWrite = 0; PCWrite = 0; Jcontrol = 2'd0; jr_target = 16'h0;
        mem_if.mem_ack = 0; mem_if.mem_rdata = 16'h0;

        step(1, 0, 0, 2'd0, 16'h0, 0, 16'h0);
        step(1, 1, 1, 2'd3, 16'h5555, 1, 16'h1111);
        #1 check("rst_mem_addr", 32'(mem_if.mem_addr), 32'(RST_PC));

        fetch(16'hF00B, 3);
        pc_op(2'd0, 16'h0); pc_op(2'd0, 16'h0); pc_op(2'd0, 16'h0);
        fetch(16'h1234, 0);
        pc_op(2'd0, 16'h0);

        pc_op(2'd3, 16'h0001);
        fetch(16'h50FE, 1);
        pc_op(2'd1, 16'h0);
        fetch(16'h3123, 0);
        pc_op(2'd2, 16'h0);
        pc_op(2'd3, 16'h0400);

        pc_op(2'd3, 16'hFFFF);
        fetch(16'h0001, 0);
        pc_op(2'd0, 16'h0);

        step(0, 1, 1, 2'd3, 16'h1234, 0, 16'h0);
        step(0, 0, 0, 2'd0, 16'h0, 1, 16'hA5A5);

        step(0, 1, 0, 2'd0, 16'h0, 0, 16'h0);
        step(0, 0, 1, 2'd1, 16'h0, 0, 16'h0);
        step(0, 0, 1, 2'd2, 16'h0, 1, 16'h0C3C);

        step(0, 0, 0, 2'd0, 16'h0, 1, 16'hDEAD);

        step(0, 1, 0, 2'd0, 16'h0, 0, 16'h0);
        idle(1);
        step(1, 0, 0, 2'd0, 16'h0, 0, 16'h0);
        step(0, 0, 0, 2'd0, 16'h0, 1, 16'hBEEF);
        fetch(16'h7777, 0);

        step(0, 1, 0, 2'd0, 16'h0, 0, 16'h0);
        idle(20);
        step(0, 0, 0, 2'd0, 16'h0, 1, 16'h4242);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            if (m_busy && !m_gap) ack = ($urandom_range(2) == 0);
            else                  ack = ($urandom_range(7) == 0);
            step(1'($urandom_range(99) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 2'($urandom_range(3)), 16'($urandom), ack, 16'($urandom));
        end
        idle(3);

        @(posedge CLK);
        #2;
        check("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("dec_q_drained", 32'(dec_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage for the 16-bit multi-register accumulator processor. Holds the program counter and instruction register, runs a request/acknowledge read handshake to instruction memory, and decodes the IR fields consumed by the multi-cycle control unit (Opcode, Func, toaccIn, noOp). It also applies PC updates commanded by the control unit (PCWrite, Jcontrol) and exposes the PC and sign-extended immediate to the datapath.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 15, cycles in REQ without ack before retry. Used only with FETCH_TIMEOUT_EN.
- CLK  in  1  clock; all state changes on posedge.
- Reset  in  1  reset Reset, synchronous, active-high; clock CLK.
- IRWrite  in  1  fetch-next-instruction request from control unit.
- PCWrite  in  1  PC update strobe.
- Jcontrol  in  2  PC source: 0 = +1, 1 = branch relative, 2 = jump absolute, 3 = jump register.
- jr_target  in  16  PC source for Jcontrol=3 (ALU result register).
- mem_ack  in  1  instruction memory read done; mem_rdata valid this cycle.
- mem_rdata  in  16  instruction word.
- mem_req  out  1  read request; held until ack.
- mem_addr  out  16  fetch address, stable while mem_req=1.
- Opcode  out  4  IR[15:12].
- Func  out  3  IR[2:0].
- toaccIn  out  1  IR[3].
- noOp  out  1  1 = IR not valid; control unit must not decode.
- ir  out  16  instruction register.
- imm_sext  out  16  IR[7:0] sign-extended.
- pc  out  16  current PC, also the jal link value.
- fetch_err  out  1  sticky timeout flag.

## Operation
- Reset values: pc=RESET_PC, ir=16'h0000, noOp=1, mem_req=0, mem_addr=RESET_PC, fetch_err=0, inc_done=0, state IDLE. Reset dominates every other input.
- FSM states:
  - IDLE: mem_req=0. IRWrite=1 → latch fetch_addr=pc, set noOp=1, go to REQ.
  - REQ: mem_req=1, mem_addr=fetch_addr. mem_ack=1 → ir=mem_rdata, noOp=0, inc_done=0, go to IDLE. IRWrite in REQ is ignored.
- mem_ack is sampled only while mem_req=1. Ack on the first REQ cycle is legal. Ack in IDLE is ignored.
- PC update occurs on a clock edge with PCWrite=1:
  - Jcontrol=0: pc=pc+1, only when noOp=0 and inc_done=0; then sets inc_done=1. This gives at most one increment per fetched instruction; repeated increment strobes are dropped.
  - Jcontrol=1: pc=pc+imm_sext, using the PC value before the edge.
  - Jcontrol=2: pc={pc[15:12], ir[11:0]}.
  - Jcontrol=3: pc=jr_target.
  - Jcontrol 1-3 are always accepted, including during REQ. mem_addr is unaffected until the next fetch.
- All PC arithmetic is modulo 2^16: 16'hFFFF+1 → 16'h0000; a negative offset below 0 wraps.
- IRWrite and PCWrite in the same cycle from IDLE: the fetch uses the pre-update pc, and the PC update also takes effect.
- Decode outputs are combinational from ir. Their values are don't-care while noOp=1.

## Timing
- IRWrite high at edge N → mem_req=1 and noOp=1 from N+1.
- mem_ack high at edge M → ir and noOp=0 visible after M. The minimum IRWrite-to-valid latency is 2 cycles.
- PC updates are visible one cycle after the strobe edge.
- Reset mid-fetch: mem_req drops the next cycle and any later ack for that request is ignored (the block is in IDLE). The first IRWrite after reset fetches from RESET_PC.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter runs in REQ.
  - On reaching TIMEOUT_CYCLES without ack: mem_req drops for one cycle, fetch_err is set (sticky until Reset), and the request is re-issued at the same fetch_addr.
  - The counter clears on ack, on retry and on Reset.
- FETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; fetch_err is tied to 0.

## Test plan
- Reset with RESET_PC=16'h0010, then IRWrite pulse, ack after 3 cycles with rdata=16'hF00B → mem_addr=16'h0010; Opcode=15, Func=3, toaccIn=1; noOp=0 one cycle after ack.
- After a valid fetch, hold PCWrite=1 with Jcontrol=0 for 3 cycles at pc=16'h0010 → pc=16'h0011 only. Next fetch, then one more increment → 16'h0012.
- ir=16'h50FE (imm=-2) at pc=16'h0001, PCWrite with Jcontrol=1 → pc=16'hFFFF. Then ir=16'h3123 with Jcontrol=2 → pc=16'hF123. Jcontrol=3 with jr_target=16'h0400 → pc=16'h0400.
- pc=16'hFFFF, valid IR, PCWrite with Jcontrol=0 → pc=16'h0000.
- Reset asserted during REQ, then ack the following cycle → mem_req=0, noOp=1, ir unchanged at 16'h0000.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → mem_req low for one cycle after 4 REQ cycles, then high again; fetch_err=1 and stays 1 after a later ack.
